// File: rtl/mac_tile_sched_if.sv
// Tile command, operand-buffer, MAC and collector signals of the tile scheduler.
// master = command front-end / MAC-side environment, slave = the scheduler.
interface mac_tile_sched_if #(
  parameter int ADDR_W = 11
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [5:0]        cmd_kblocks;
  logic              mac_stall;
  logic              calc_done;
  logic              ppu_done;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic              mac_valid;
  logic              is_int8_mode;
  logic              is_int4_mode;
  logic              is_vsq;
  logic              acc_start;
  logic              acc_ppu;
  logic              tile_done;
  logic              busy;
  logic              err_cmd;
  logic [31:0]       perf_busy;
  logic [31:0]       perf_stall;

  modport master (
    output cmd_valid, cmd_mode, cmd_kblocks, mac_stall, calc_done, ppu_done,
    input  cmd_ready, buf_rd_en, buf_rd_addr, mac_valid, is_int8_mode, is_int4_mode,
           is_vsq, acc_start, acc_ppu, tile_done, busy, err_cmd, perf_busy, perf_stall
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_kblocks, mac_stall, calc_done, ppu_done,
    output cmd_ready, buf_rd_en, buf_rd_addr, mac_valid, is_int8_mode, is_int4_mode,
           is_vsq, acc_start, acc_ppu, tile_done, busy, err_cmd, perf_busy, perf_stall
  );
endinterface

// File: rtl/mac_tile_sched.sv
// Tile controller for the 16-lane MAC array: command intake, operand reads, PPU drain handoff.
// Optional busy/stall performance counters are enabled with `define MAC_SCHED_PERF_EN.
module mac_tile_sched #(
  parameter int ADDR_W     = 11,
  parameter int K_MAX      = 63,
  parameter int INT8_STEPS = 32,
  parameter int INT4_STEPS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mac_tile_sched_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, PPU, DONE} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] step_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [2:0]        mode_oh_reg;   // {int8, int4, vsq}
  logic              cmd_ready_reg;
  logic              busy_reg;
  logic              acc_start_reg;
  logic              acc_ppu_reg;
  logic              tile_done_reg;
  logic              err_reg;
  logic              mac_valid_reg;

  logic              accept;
  logic              cmd_legal;
  logic              rd_en;
  logic [ADDR_W-1:0] cmd_last;
  logic [2:0]        cmd_oh;

  always_comb begin
    accept    = bus.cmd_valid & cmd_ready_reg;
    cmd_legal = (bus.cmd_mode != 2'b11) && (bus.cmd_kblocks != 6'd0)
                && (32'(bus.cmd_kblocks) <= K_MAX);
    cmd_last  = (bus.cmd_mode == 2'b00)
                ? ADDR_W'(32'(bus.cmd_kblocks) * INT8_STEPS - 1)
                : ADDR_W'(32'(bus.cmd_kblocks) * INT4_STEPS - 1);
    cmd_oh    = 3'b000;
    case (bus.cmd_mode)
      2'b00:   cmd_oh = 3'b100;
      2'b01:   cmd_oh = 3'b010;
      2'b10:   cmd_oh = 3'b001;
      default: cmd_oh = 3'b000;
    endcase
    rd_en = (state_reg == RUN) && !bus.mac_stall;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      step_reg      <= '0;
      last_reg      <= '0;
      mode_oh_reg   <= '0;
      cmd_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      acc_start_reg <= 1'b0;
      acc_ppu_reg   <= 1'b0;
      tile_done_reg <= 1'b0;
      err_reg       <= 1'b0;
      mac_valid_reg <= 1'b0;
    end else begin
      acc_start_reg <= 1'b0;
      acc_ppu_reg   <= 1'b0;
      tile_done_reg <= 1'b0;
      // One-cycle SRAM latency; a later stall does not cancel data already in flight.
      mac_valid_reg <= rd_en;
      case (state_reg)
        IDLE: begin
          cmd_ready_reg <= 1'b1;
          if (accept) begin
            if (cmd_legal) begin
              state_reg     <= LOAD;
              last_reg      <= cmd_last;
              mode_oh_reg   <= cmd_oh;
              acc_start_reg <= 1'b1;
              cmd_ready_reg <= 1'b0;
              busy_reg      <= 1'b1;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        LOAD: begin
          step_reg  <= '0;
          state_reg <= RUN;
        end
        RUN: begin
          // The address stays on the final step so it holds its last value after RUN.
          if (rd_en) begin
            if (step_reg == last_reg) state_reg <= WAIT;
            else                      step_reg  <= step_reg + 1'b1;
          end
        end
        WAIT: begin
          if (bus.calc_done) begin
            state_reg   <= PPU;
            acc_ppu_reg <= 1'b1;
          end
        end
        PPU: begin
          if (bus.ppu_done) begin
            state_reg     <= DONE;
            tile_done_reg <= 1'b1;
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          cmd_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
          mode_oh_reg   <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready_reg;
  assign bus.busy         = busy_reg;
  assign bus.buf_rd_en    = rd_en;
  assign bus.buf_rd_addr  = step_reg;
  assign bus.mac_valid    = mac_valid_reg;
  assign bus.is_int8_mode = mode_oh_reg[2];
  assign bus.is_int4_mode = mode_oh_reg[1];
  assign bus.is_vsq       = mode_oh_reg[0];
  assign bus.acc_start    = acc_start_reg;
  assign bus.acc_ppu      = acc_ppu_reg;
  assign bus.tile_done    = tile_done_reg;
  assign bus.err_cmd      = err_reg;

`ifdef MAC_SCHED_PERF_EN
  logic [31:0] perf_busy_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_busy_reg  <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (busy_reg && (perf_busy_reg != '1))
        perf_busy_reg <= perf_busy_reg + 1'b1;
      if ((state_reg == RUN) && bus.mac_stall && (perf_stall_reg != '1))
        perf_stall_reg <= perf_stall_reg + 1'b1;
    end
  end

  assign bus.perf_busy  = perf_busy_reg;
  assign bus.perf_stall = perf_stall_reg;
`else
  assign bus.perf_busy  = '0;
  assign bus.perf_stall = '0;
`endif

endmodule
